// File: rtl/uex_mem_arb.sv
// Round-robin arbiter sharing one memory port among N_REQ requesters. It has a
// registered request stage, an in-flight ID FIFO, and in-order response routing.
module uex_mem_arb #(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_rdata,
  output logic                          err_unexp_rsp
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_wp, r_rp;
  logic [IDW-1:0] r_fifo [MAX_OUTSTANDING];
  logic           r_mem_valid;
  mem_req_t       r_out;
  logic           r_err;

  logic [IDW-1:0]   w_win;
  logic             w_any;
  logic             w_can_issue;
  logic             w_accept;
  logic             w_pop;
  logic [N_REQ-1:0] w_req_ready;
  logic [N_REQ-1:0] w_rsp_valid;
  mem_req_t         w_sel;

  function automatic logic [PW-1:0] inc_p(input logic [PW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  // Scan from the highest offset down so the requester nearest ptr wins last.
  always_comb begin
    int idx;
    idx   = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        w_win = IDW'(idx);
        w_any = 1'b1;
      end
    end
  end

  // Reset gates issue so req_ready reads zero while reset_n is held low.
  assign w_can_issue = reset_n && (!r_mem_valid || mem_ready) &&
                       (r_cnt != CW'(MAX_OUTSTANDING));
  assign w_accept    = w_any && w_can_issue;
  assign w_pop       = mem_rsp_valid && (r_cnt != '0);

  always_comb begin
    w_req_ready = '0;
    if (w_accept) w_req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      w_rsp_valid[i] = w_pop && (r_fifo[r_rp] == IDW'(i));
  end

  always_comb begin
    w_sel.we    = req_we[w_win];
    w_sel.addr  = req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel.wdata = req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_mem_valid <= 1'b0;
      r_out       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(w_accept) - CW'(w_pop);
      if (w_accept) begin
        r_out       <= w_sel;
        r_mem_valid <= 1'b1;
        r_wp        <= inc_p(r_wp);
        r_ptr       <= (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      end else if (mem_ready) begin
        r_mem_valid <= 1'b0;
      end
      if (w_pop) r_rp <= inc_p(r_rp);
      if (mem_rsp_valid && (r_cnt == '0)) r_err <= 1'b1;
    end
  end

  // ID storage needs no reset: occupancy is tracked by r_cnt.
  always_ff @(posedge clock) begin
    if (w_accept) r_fifo[r_wp] <= w_win;
  end

  assign req_ready     = w_req_ready;
  assign rsp_valid     = w_rsp_valid;
  assign rsp_rdata     = mem_rsp_rdata;
  assign mem_valid     = r_mem_valid;
  assign mem_we        = r_out.we;
  assign mem_addr      = r_out.addr;
  assign mem_wdata     = r_out.wdata;
  assign err_unexp_rsp = r_err;

endmodule
